// File: rtl/icache.sv
// ----------------------------------------------------------------------------
// icache -- direct-mapped instruction cache, one 32-bit word per line.
//
// Sits between the IF stage and the memory controller's instruction port.
// Hits are returned one cycle after the request edge. A miss holds a fetch
// request (mem_req/mem_addr) until the memory controller hands back the word
// tagged with the matching PC; the line is then filled and the word returned.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           invalidate every line, abandon any miss in flight
//   if_req, if_pc   fetch request from IF (held until if_valid or redirect)
//   if_valid        one-cycle pulse qualifying if_inst / if_inst_pc
//   if_inst         returned instruction word
//   if_inst_pc      word-aligned address of if_inst
//   mem_req         fetch request to memory controller (combinational)
//   mem_addr        fetch address to memory controller (registered)
//   mem_inst        word from memory controller
//   mem_pc          address tag of mem_inst
//   mem_done        memory port idle / just completed
//
// Optional build: define ICACHE_STATS_EN to add saturating counters
//   stat_hits (hit lookups) and stat_misses (miss entries, not redirects).
// ----------------------------------------------------------------------------
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_inst_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    input  logic [31:0] mem_pc,
    input  logic        mem_done
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic {S_IDLE, S_MISS} state_t;

    // Storage
    logic [31:0]         data_q [LINES];
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [LINES-1:0]    valid_q, valid_d;

    // Control / output registers
    state_t      state_q, state_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] if_inst_pc_q, if_inst_pc_d;
    logic [31:0] miss_addr_q, miss_addr_d;
    logic        busy_seen_q, busy_seen_d;

    logic                  wr_en;
    logic                  hit_evt;
    logic                  miss_evt;
    logic                  fill_now;
    logic                  hit;
    logic [31:0]           pc_al;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_BITS-1:0]   miss_tag;
    logic                  unused_pc_lsbs;

    assign unused_pc_lsbs = ^if_pc[1:0];

    assign pc_al    = {if_pc[31:2], 2'b00};
    assign req_idx  = if_pc[INDEX_BITS+1:2];
    assign req_tag  = if_pc[31:INDEX_BITS+2];
    assign miss_idx = miss_addr_q[INDEX_BITS+1:2];
    assign miss_tag = miss_addr_q[31:INDEX_BITS+2];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // busy_seen guarantees the memory port has gone busy since this miss was
    // issued, so a done/pc pair left over from an earlier fetch of the same
    // address cannot be mistaken for our completion. IF must still be asking
    // for the same word, otherwise the result belongs to nobody.
    assign fill_now = (state_q == S_MISS) && mem_done && busy_seen_q &&
                      (mem_pc == miss_addr_q) && if_req && (pc_al == miss_addr_q);

    // Dropped in the fill cycle so the controller does not start a second fetch.
    assign mem_req    = (state_q == S_MISS) && !fill_now;
    assign mem_addr   = miss_addr_q;
    assign if_valid   = if_valid_q;
    assign if_inst    = if_inst_q;
    assign if_inst_pc = if_inst_pc_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        if_valid_d   = if_valid_q;
        if_inst_d    = if_inst_q;
        if_inst_pc_d = if_inst_pc_q;
        miss_addr_d  = miss_addr_q;
        busy_seen_d  = busy_seen_q;
        wr_en        = 1'b0;
        hit_evt      = 1'b0;
        miss_evt     = 1'b0;

        if (flush) begin
            valid_d    = '0;
            state_d    = S_IDLE;
            if_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (if_valid_q) begin
                        // Previous word just delivered; give IF a cycle to move on.
                        if_valid_d = 1'b0;
                    end else if (if_req) begin
                        if (hit) begin
                            hit_evt      = 1'b1;
                            if_valid_d   = 1'b1;
                            if_inst_d    = data_q[req_idx];
                            if_inst_pc_d = pc_al;
                        end else begin
                            miss_evt    = 1'b1;
                            state_d     = S_MISS;
                            miss_addr_d = pc_al;
                            busy_seen_d = 1'b0;
                        end
                    end
                end
                S_MISS: begin
                    if_valid_d  = 1'b0;
                    busy_seen_d = busy_seen_q | ~mem_done;
                    if (fill_now) begin
                        wr_en             = 1'b1;
                        valid_d[miss_idx] = 1'b1;
                        if_valid_d        = 1'b1;
                        if_inst_d         = mem_inst;
                        if_inst_pc_d      = miss_addr_q;
                        state_d           = S_IDLE;
                    end else if (if_req && (pc_al != miss_addr_q)) begin
                        // Redirect: chase the new address straight from memory.
                        miss_addr_d = pc_al;
                        busy_seen_d = 1'b0;
                    end else if (!if_req) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            if_valid_q   <= 1'b0;
            if_inst_q    <= '0;
            if_inst_pc_q <= '0;
            miss_addr_q  <= '0;
            busy_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            if_valid_q   <= if_valid_d;
            if_inst_q    <= if_inst_d;
            if_inst_pc_q <= if_inst_pc_d;
            miss_addr_q  <= miss_addr_d;
            busy_seen_q  <= busy_seen_d;
        end
    end

    // Data/tag need no reset: valid_q gates every use.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            data_q[miss_idx] <= mem_inst;
            tag_q[miss_idx]  <= miss_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_misses_q, stat_misses_d;

    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (hit_evt && (stat_hits_q != 32'hFFFF_FFFF))
            stat_hits_d = stat_hits_q + 32'd1;
        if (miss_evt && (stat_misses_q != 32'hFFFF_FFFF))
            stat_misses_d = stat_misses_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`else
    logic unused_evts;
    assign unused_evts = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_icache.sv
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [31:0] if_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_inst_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic [31:0] mem_pc;
    logic        mem_done;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    int checks   = 0;
    int failures = 0;

    icache #(.INDEX_BITS(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .if_req     (if_req),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_inst_pc (if_inst_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_inst   (mem_inst),
        .mem_pc     (mem_pc),
        .mem_done   (mem_done)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits  (stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Miss on addr (verified as a miss), one busy cycle, then fill with inst.
    task automatic do_fill(input logic [31:0] addr, input logic [31:0] inst);
        if_req = 1'b1;
        if_pc  = addr;
        tick();
        chk("fill_miss_req", {31'd0, mem_req}, 32'd1);
        chk("fill_miss_noval", {31'd0, if_valid}, 32'd0);
        chk("fill_miss_addr", mem_addr, addr);
        mem_done = 1'b0;
        tick();
        mem_done = 1'b1;
        mem_pc   = addr;
        mem_inst = inst;
        tick();
        chk("fill_valid", {31'd0, if_valid}, 32'd1);
        chk("fill_inst", if_inst, inst);
        chk("fill_pc", if_inst_pc, addr);
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_pc = '0;
        mem_inst = '0; mem_pc = '0; mem_done = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        chk("rst_inst_pc", if_inst_pc, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("rst_stat_hits", stat_hits, 32'd0);
        chk("rst_stat_misses", stat_misses, 32'd0);
`endif
        rst = 1'b0;

        // Cold miss on 0: stale done/pc=0 must not fill before busy is seen
        if_req = 1'b1; if_pc = 32'h0;
        tick();
        chk("cold_req", {31'd0, mem_req}, 32'd1);
        chk("cold_addr", mem_addr, 32'h0);
        mem_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("cold_wait_req", {31'd0, mem_req}, 32'd1);
            chk("cold_wait_val", {31'd0, if_valid}, 32'd0);
        end
        mem_done = 1'b1; mem_pc = 32'h0; mem_inst = 32'h0000_0013;
        #1;
        chk("cold_fill_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        chk("cold_valid", {31'd0, if_valid}, 32'd1);
        chk("cold_inst", if_inst, 32'h0000_0013);
        chk("cold_inst_pc", if_inst_pc, 32'h0);
        chk("cold_post_req", {31'd0, mem_req}, 32'd0);
        if_req = 1'b0;
        tick();
        chk("cold_pulse", {31'd0, if_valid}, 32'd0);

        // Warm hit on 0, if_req held: one word per two cycles
        if_req = 1'b1; if_pc = 32'h0; mem_inst = 32'hFFFF_FFFF;
        tick();
        chk("hit_valid", {31'd0, if_valid}, 32'd1);
        chk("hit_inst", if_inst, 32'h0000_0013);
        chk("hit_pc", if_inst_pc, 32'h0);
        chk("hit_no_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("hit_gap", {31'd0, if_valid}, 32'd0);
        tick();
        chk("hit_again", {31'd0, if_valid}, 32'd1);
        if_req = 1'b0;
        tick();

        // Conflict: 0x4 and 0x104 share index 1
        do_fill(32'h4, 32'h0000_00A4);
        if_req = 1'b1; if_pc = 32'h4;
        tick();
        chk("conf_hit4", if_inst, 32'h0000_00A4);
        if_req = 1'b0;
        tick();
        do_fill(32'h104, 32'h0000_01B4);
        do_fill(32'h4, 32'h0000_00A5);

        // Stale-done guard after flush
        do_fill(32'h8, 32'h0000_0088);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if_req = 1'b1; if_pc = 32'h8; mem_inst = 32'h0000_0099;
        tick();
        chk("stale_miss", {31'd0, mem_req}, 32'd1);
        tick();
        chk("stale_nofill1", {31'd0, if_valid}, 32'd0);
        tick();
        chk("stale_nofill2", {31'd0, if_valid}, 32'd0);
        chk("stale_req_held", {31'd0, mem_req}, 32'd1);
        mem_done = 1'b0;
        tick();
        mem_done = 1'b1;
        tick();
        chk("stale_fill_val", {31'd0, if_valid}, 32'd1);
        chk("stale_fill_inst", if_inst, 32'h0000_0099);
        chk("stale_fill_pc", if_inst_pc, 32'h8);
        if_req = 1'b0;
        tick();

        // Redirect mid-miss
        if_req = 1'b1; if_pc = 32'h10;
        tick();
        chk("redir_addr0", mem_addr, 32'h10);
        mem_done = 1'b0;
        tick();
        tick();
        if_pc = 32'h20;
        tick();
        chk("redir_addr1", mem_addr, 32'h20);
        chk("redir_req", {31'd0, mem_req}, 32'd1);
        tick();
        mem_done = 1'b1; mem_pc = 32'h10; mem_inst = 32'h0000_DEAD;
        tick();
        chk("redir_late_ignored", {31'd0, if_valid}, 32'd0);
        chk("redir_late_req", {31'd0, mem_req}, 32'd1);
        mem_pc = 32'h20; mem_inst = 32'h0000_2020;
        tick();
        chk("redir_fill_val", {31'd0, if_valid}, 32'd1);
        chk("redir_fill_pc", if_inst_pc, 32'h20);
        chk("redir_fill_inst", if_inst, 32'h0000_2020);
        if_req = 1'b0;
        tick();
        // 0x10 was never written; then abandon via if_req drop
        if_req = 1'b1; if_pc = 32'h10;
        tick();
        chk("redir_10_miss", {31'd0, mem_req}, 32'd1);
        chk("redir_10_noval", {31'd0, if_valid}, 32'd0);
        if_req = 1'b0;
        tick();
        chk("abandon_req", {31'd0, mem_req}, 32'd0);

        // Flush mid-miss
        if_req = 1'b1; if_pc = 32'h30;
        tick();
        chk("flush_pre_req", {31'd0, mem_req}, 32'd1);
        flush = 1'b1; if_req = 1'b0;
        tick();
        flush = 1'b0;
        chk("flush_req_drop", {31'd0, mem_req}, 32'd0);
        chk("flush_noval", {31'd0, if_valid}, 32'd0);
        if_req = 1'b1; if_pc = 32'h0;
        tick();
        chk("flush_0_misses", {31'd0, mem_req}, 32'd1);
        chk("flush_0_noval", {31'd0, if_valid}, 32'd0);
        if_req = 1'b0;
        tick();
        if_req = 1'b1; if_pc = 32'h20;
        tick();
        chk("flush_20_misses", {31'd0, mem_req}, 32'd1);
        chk("flush_20_addr", mem_addr, 32'h20);

        // Reset mid-miss
        rst = 1'b1;
        tick();
        chk("rst2_valid", {31'd0, if_valid}, 32'd0);
        chk("rst2_inst", if_inst, 32'd0);
        chk("rst2_inst_pc", if_inst_pc, 32'd0);
        chk("rst2_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst2_mem_addr", mem_addr, 32'd0);
        rst = 1'b0; if_req = 1'b0;
        tick();
        if_req = 1'b1; if_pc = 32'h20;
        tick();
        chk("rst2_20_misses", {31'd0, mem_req}, 32'd1);
        chk("rst2_20_noval", {31'd0, if_valid}, 32'd0);
        if_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the IF stage and the memory controller's instruction port.
- Serves hits with 1-cycle registered latency.
- On a miss, holds a fetch request to the memory controller and waits for the 4-byte assembled word, tagged with its PC.
- Fills the line and returns the instruction to IF.

Parameters:
- INDEX_BITS, 6, line index width; the cache holds 2^INDEX_BITS lines of one 32-bit word each.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  invalidate all lines (fence.i / redirect-clean)
- if_req  in  1  IF requests the instruction at if_pc; held until if_valid or redirect
- if_pc  in  32  fetch address; bits [1:0] ignored (treated as 0)
- if_valid  out  1  one-cycle pulse: if_inst / if_inst_pc valid
- if_inst  out  32  instruction word
- if_inst_pc  out  32  address of if_inst
- mem_req  out  1  to memory controller inst_req
- mem_addr  out  32  to memory controller inst_addr_i
- mem_inst  in  32  from memory controller inst_o
- mem_pc  in  32  from memory controller inst_pc
- mem_done  in  1  from memory controller inst_done_o; high when that port is idle or has just completed

Behaviour:
- Address split: index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]. Arrays: data[32], tag, valid bit per line.
- Reset: all valid bits 0, state IDLE, if_valid 0, if_inst 0, if_inst_pc 0, miss_addr 0, busy_seen 0. mem_req is therefore 0 in the cycle after reset. Reset mid-miss abandons the miss; the memory controller's in-flight result is ignored.
- Priority per edge: rst > flush > state logic.
- flush: clear all valid bits in one cycle, state <= IDLE, if_valid <= 0, in-flight miss abandoned.
- mem_addr = miss_addr, registered.
- mem_req is combinational: (state==MISS) && !fill_now. It drops in the fill cycle so the memory controller does not start a duplicate fetch.
- IDLE:
  - If if_valid==1, the request is considered consumed. Clear if_valid and ignore if_req this edge, so a hit gives 1 instruction per 2 cycles.
  - Else if if_req, look up the index:
    - Hit (valid && tag match): if_valid <= 1, if_inst <= data, if_inst_pc <= {if_pc[31:2],2'b00}.
    - Miss: state <= MISS, miss_addr <= aligned if_pc, busy_seen <= 0.
- MISS:
  - busy_seen <= 1 whenever mem_done==0 is sampled. This guards against the stale done/pc left over from an earlier fetch.
  - fill_now = mem_done && busy_seen && mem_pc==miss_addr && if_req && aligned if_pc==miss_addr.
  - On fill_now: write data/tag/valid at index(miss_addr), if_valid <= 1, if_inst <= mem_inst, if_inst_pc <= miss_addr, state <= IDLE.
  - Redirect (if_req && aligned if_pc != miss_addr): miss_addr <= new pc, busy_seen <= 0, stay in MISS. The memory controller restarts on the address change. No lookup of the new pc is done; it is fetched from memory and filled.
  - if_req==0: abandon, state <= IDLE, no array write.
- A completion whose mem_pc != miss_addr never writes the arrays.
- Memory-controller data/RAM requests may delay completion arbitrarily; the cache holds mem_req/mem_addr stable meanwhile.
- if_valid is never high for two consecutive cycles.

Optional Feature:
- Macro ICACHE_STATS_EN. When defined, adds two outputs:
  - stat_hits  out  32: +1 per hit lookup.
  - stat_misses  out  32: +1 per MISS entry, redirects excluded.
- Both counters saturate at 32'hFFFFFFFF, reset to 0 on rst, and are unaffected by flush.
- When undefined, these ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
- Cold miss: after reset, if_req=1, if_pc=0x00000000; memory model returns mem_inst=0x00000013 with mem_pc=0 after mem_done low for 5 cycles -> mem_req high until the fill cycle, then if_valid pulse with if_inst=0x00000013, if_inst_pc=0.
- Warm hit: re-request pc 0 -> if_valid the cycle after the request edge, mem_req stays 0, if_inst=0x00000013; the next cycle if_valid=0 even though if_req is still high.
- Conflict: fill 0x00000004, then request 0x00000104 (same index, INDEX_BITS=6) -> miss; after fill, 0x00000004 misses again.
- Stale done guard: miss to 0x00000008 immediately after a fill of 0x00000008 that was invalidated by flush, with mem_done still high and mem_pc=0x8 -> no fill until mem_done has gone low and returned high.
- Redirect mid-miss: miss on 0x10; two cycles later if_pc=0x20 -> mem_addr=0x20; a late completion with mem_pc=0x10 is ignored; fill for 0x20 returns if_inst_pc=0x20.
- Flush/reset mid-miss: assert flush during MISS -> mem_req 0 next cycle, all lines invalid, previous hit address now misses. Repeat with rst -> outputs at reset values.
